// File: rtl/div_sequencer.sv
// Shared iterative 64/32 divide unit for UDIV/SDIV/UDIVCC/SDIVCC with V8 saturation,
// icc generation and divide-by-zero / illegal-instruction traps, one operation in flight.
module div_sequencer #(
    parameter int NTHREAD = 64,
    parameter int TIDW    = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [TIDW-1:0] req_tid,
    input  logic [5:0]      req_op,
    input  logic [31:0]     req_y,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_op2,
    input  logic            abort,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [TIDW-1:0] resp_tid,
    output logic [31:0]     resp_result,
    output logic            resp_icc_we,
    output logic [3:0]      resp_icc,
    output logic            resp_trap,
    output logic [5:0]      resp_tt,
    output logic [1:0]      dbg_state
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic [5:0] OP_UDIV   = 6'h0E;
    localparam logic [5:0] OP_SDIV   = 6'h0F;
    localparam logic [5:0] OP_UDIVCC = 6'h1E;
    localparam logic [5:0] OP_SDIVCC = 6'h1F;
    localparam logic [5:0] TT_ILLEGAL = 6'h02;
    localparam logic [5:0] TT_DIVZERO = 6'h2A;

    if (NTHREAD != (1 << TIDW)) begin : g_tidw_check
        $error("TIDW must equal log2(NTHREAD)");
    end

    logic [1:0]      state, state_nx;
    logic [6:0]      cnt;
    logic [63:0]     dvd;      // dividend magnitude, shifts into the quotient
    logic [31:0]     dsr;
    logic [32:0]     rem;
    logic [TIDW-1:0] tid_q;
    logic            cc_q, sgn_q, neg_q;

    logic        accept, op_ok, div_zero;
    logic [63:0] dvd_in, dvd_mag;
    logic [31:0] dsr_mag;
    logic [32:0] trial, rem_nx;
    logic        qbit;
    logic [31:0] fix_res;
    logic        fix_v;

    assign accept     = req_valid && req_ready && (state == S_IDLE);
    assign op_ok      = (req_op == OP_UDIV) || (req_op == OP_SDIV) ||
                        (req_op == OP_UDIVCC) || (req_op == OP_SDIVCC);
    assign div_zero   = (req_op2 == 32'd0);
    assign dvd_in     = {req_y, req_rs1};
    assign dvd_mag    = (req_op[0] && req_y[31]) ? -dvd_in : dvd_in;
    assign dsr_mag    = (req_op[0] && req_op2[31]) ? -req_op2 : req_op2;
    assign resp_valid = (state == S_RESP);
    assign dbg_state  = state;

    // Restoring step; rem never exceeds the divisor, so bit 32 only matters defensively.
    assign trial  = {rem[31:0], dvd[63]};
    assign qbit   = rem[32] || (trial >= {1'b0, dsr});
    assign rem_nx = qbit ? (trial - {1'b0, dsr}) : trial;

    always_comb begin
        fix_res = dvd[31:0];
        fix_v   = 1'b0;
        if (!sgn_q) begin
            if (|dvd[63:32]) begin
                fix_res = 32'hFFFF_FFFF;
                fix_v   = 1'b1;
            end
        end else if (!neg_q) begin
            if (|dvd[63:31]) begin
                fix_res = 32'h7FFF_FFFF;
                fix_v   = 1'b1;
            end
        end else begin
            if ((|dvd[63:32]) || (dvd[31] && (|dvd[30:0]))) begin
                fix_res = 32'h8000_0000;
                fix_v   = 1'b1;
            end else begin
                fix_res = -dvd[31:0];
            end
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (accept) state_nx = (!op_ok || div_zero) ? S_RESP : S_CALC;
            S_CALC: if (abort) state_nx = S_IDLE;
                    else if (cnt == 7'd63) state_nx = S_FIX;
            S_FIX:  state_nx = abort ? S_IDLE : S_RESP;
            S_RESP: if (abort || resp_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            req_ready   <= 1'b1;
            cnt         <= 7'd0;
            dvd         <= 64'd0;
            dsr         <= 32'd0;
            rem         <= 33'd0;
            tid_q       <= '0;
            cc_q        <= 1'b0;
            sgn_q       <= 1'b0;
            neg_q       <= 1'b0;
            resp_tid    <= '0;
            resp_result <= 32'd0;
            resp_icc_we <= 1'b0;
            resp_icc    <= 4'd0;
            resp_trap   <= 1'b0;
            resp_tt     <= 6'd0;
        end else begin
            state     <= state_nx;
            req_ready <= (state_nx == S_IDLE);
            case (state)
                S_IDLE: if (accept) begin
                    tid_q <= req_tid;
                    cc_q  <= req_op[4];
                    sgn_q <= req_op[0];
                    neg_q <= req_op[0] && (req_y[31] ^ req_op2[31]);
                    dvd   <= dvd_mag;
                    dsr   <= dsr_mag;
                    rem   <= 33'd0;
                    cnt   <= 7'd0;
                    if (!op_ok || div_zero) begin
                        resp_tid    <= req_tid;
                        resp_result <= 32'd0;
                        resp_icc    <= 4'd0;
                        resp_icc_we <= 1'b0;
                        resp_trap   <= 1'b1;
                        resp_tt     <= op_ok ? TT_DIVZERO : TT_ILLEGAL;
                    end
                end
                S_CALC: begin
                    rem <= rem_nx;
                    dvd <= {dvd[62:0], qbit};
                    cnt <= cnt + 7'd1;
                end
                S_FIX: begin
                    resp_tid    <= tid_q;
                    resp_result <= fix_res;
                    resp_icc    <= {fix_res[31], fix_res == 32'd0, fix_v, 1'b0};
                    resp_icc_we <= cc_q;
                    resp_trap   <= 1'b0;
                    resp_tt     <= 6'd0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_div_sequencer.sv
// Directed bench for div_sequencer: arithmetic/saturation vectors, traps, latency,
// back-to-back accept, abort, response backpressure and mid-operation reset.
module tb_div_sequencer;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [5:0]  req_tid, req_op;
    logic [31:0] req_y, req_rs1, req_op2;
    logic        abort;
    logic        resp_valid, resp_ready;
    logic [5:0]  resp_tid;
    logic [31:0] resp_result;
    logic        resp_icc_we;
    logic [3:0]  resp_icc;
    logic        resp_trap;
    logic [5:0]  resp_tt;
    logic [1:0]  dbg_state;

    int errors = 0;
    int checks = 0;

    div_sequencer #(.NTHREAD(64), .TIDW(6)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid),
        .req_op(req_op), .req_y(req_y), .req_rs1(req_rs1), .req_op2(req_op2),
        .abort(abort),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_tid(resp_tid),
        .resp_result(resp_result), .resp_icc_we(resp_icc_we), .resp_icc(resp_icc),
        .resp_trap(resp_trap), .resp_tt(resp_tt), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drives a request once req_ready is seen; returns just after the accepting edge.
    task automatic request(input logic [5:0] tid, input logic [5:0] op,
                           input logic [31:0] y, input logic [31:0] rs1, input logic [31:0] op2);
        int n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("req_ready_wait", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1;
        req_tid   = tid;
        req_op    = op;
        req_y     = y;
        req_rs1   = rs1;
        req_op2   = op2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // lat = N means resp_valid first seen in cycle accept+N.
    task automatic wait_resp(output int lat);
        lat = 1;
        @(negedge clk);
        while (!resp_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic handshake(input string name);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        check({name, ".ready_after"}, {31'd0, req_ready}, 32'd1);
        check({name, ".valid_after"}, {31'd0, resp_valid}, 32'd0);
    endtask

    task automatic run_op(input string name, input logic [5:0] tid, input logic [5:0] op,
                          input logic [31:0] y, input logic [31:0] rs1, input logic [31:0] op2,
                          input int exp_lat, input logic [31:0] exp_res, input logic exp_trap,
                          input logic [5:0] exp_tt, input logic exp_we, input logic [3:0] exp_icc);
        int lat;
        request(tid, op, y, rs1, op2);
        wait_resp(lat);
        check({name, ".latency"}, lat, exp_lat);
        check({name, ".tid"}, {26'd0, resp_tid}, {26'd0, tid});
        check({name, ".trap"}, {31'd0, resp_trap}, {31'd0, exp_trap});
        check({name, ".icc_we"}, {31'd0, resp_icc_we}, {31'd0, exp_we});
        if (exp_trap) begin
            check({name, ".tt"}, {26'd0, resp_tt}, {26'd0, exp_tt});
        end else begin
            check({name, ".result"}, resp_result, exp_res);
            if (exp_we) check({name, ".icc"}, {28'd0, resp_icc}, {28'd0, exp_icc});
        end
        handshake(name);
    endtask

    initial begin
        int seen;
        int lat;
        rst = 1'b1; req_valid = 1'b0; req_tid = '0; req_op = '0;
        req_y = '0; req_rs1 = '0; req_op2 = '0; abort = 1'b0; resp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst.trap", {31'd0, resp_trap}, 32'd0);
        check("rst.icc_we", {31'd0, resp_icc_we}, 32'd0);
        check("rst.tt", {26'd0, resp_tt}, 32'd0);
        check("rst.tid", {26'd0, resp_tid}, 32'd0);
        check("rst.result", resp_result, 32'd0);
        check("rst.icc", {28'd0, resp_icc}, 32'd0);
        check("rst.state", {30'd0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op("udiv_basic",   6'd5,  6'h0E, 32'h0,        32'd100,      32'd7,        66, 32'd14,       0, 6'h00, 0, 4'b0000);
        run_op("udivcc_sat",   6'd1,  6'h1E, 32'h1,        32'h0,        32'd1,        66, 32'hFFFFFFFF, 0, 6'h00, 1, 4'b1010);
        run_op("sdivcc_neg",   6'd2,  6'h1F, 32'hFFFFFFFF, 32'hFFFFFF9C, 32'd7,        66, 32'hFFFFFFF2, 0, 6'h00, 1, 4'b1000);
        run_op("sdivcc_psat",  6'd3,  6'h1F, 32'h0,        32'h80000000, 32'd1,        66, 32'h7FFFFFFF, 0, 6'h00, 1, 4'b0010);
        run_op("sdiv_nsat",    6'd4,  6'h0F, 32'hFFFFFFFF, 32'h0,        32'd1,        66, 32'h80000000, 0, 6'h00, 0, 4'b0000);
        run_op("sdivcc_min64", 6'd6,  6'h1F, 32'h80000000, 32'h0,        32'd1,        66, 32'h80000000, 0, 6'h00, 1, 4'b1010);
        run_op("sdivcc_min32", 6'd7,  6'h1F, 32'hFFFFFFFF, 32'h80000000, 32'd1,        66, 32'h80000000, 0, 6'h00, 1, 4'b1000);
        run_op("sdiv_negdsr",  6'd8,  6'h0F, 32'h0,        32'd100,      32'hFFFFFFF9, 66, 32'hFFFFFFF2, 0, 6'h00, 0, 4'b0000);
        run_op("udivcc_zero",  6'd63, 6'h1E, 32'h0,        32'd5,        32'd7,        66, 32'd0,        0, 6'h00, 1, 4'b0100);
        run_op("udiv_div0",    6'd10, 6'h0E, 32'h0,        32'd9,        32'd0,        1,  32'd0,        1, 6'h2A, 0, 4'b0000);
        run_op("illegal_op",   6'd11, 6'h00, 32'h0,        32'd9,        32'd3,        1,  32'd0,        1, 6'h02, 0, 4'b0000);
        run_op("sdivcc_div0",  6'd12, 6'h1F, 32'h0,        32'd9,        32'd0,        1,  32'd0,        1, 6'h2A, 0, 4'b0000);

        // Abort during CALC: asserted in cycle accept+30.
        request(6'd13, 6'h0E, 32'h0, 32'd1000, 32'd10);
        repeat (29) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
        check("abort.ready", {31'd0, req_ready}, 32'd1);
        check("abort.state", {30'd0, dbg_state}, 32'd0);
        seen = 0;
        repeat (80) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("abort.no_resp", seen, 0);
        run_op("after_abort", 6'd14, 6'h0E, 32'h0, 32'd1000, 32'd10, 66, 32'd100, 0, 6'h00, 0, 4'b0000);

        // Backpressure: resp_ready low for 10 cycles in RESP.
        request(6'd20, 6'h1E, 32'h0, 32'hFFFFFFFF, 32'd3);
        wait_resp(lat);
        check("hold.latency", lat, 66);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (!resp_valid || req_ready || resp_result !== 32'h55555555 ||
                resp_tid !== 6'd20 || resp_icc !== 4'b0000 || resp_icc_we !== 1'b1) seen++;
            @(negedge clk);
        end
        check("hold.stable", seen, 0);
        handshake("hold");

        // Reset pulse mid-CALC.
        request(6'd9, 6'h1E, 32'h0, 32'd50, 32'd5);
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst.req_ready", {31'd0, req_ready}, 32'd1);
        check("mid_rst.resp_valid", {31'd0, resp_valid}, 32'd0);
        check("mid_rst.outputs",
              {resp_result[31:0]} | {26'd0, resp_tt} | {26'd0, resp_tid} | {28'd0, resp_icc}, 32'd0);
        check("mid_rst.flags", {30'd0, resp_trap, resp_icc_we}, 32'd0);
        check("mid_rst.state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (100) begin
            @(negedge clk);
            if (resp_valid || !req_ready) seen++;
        end
        check("mid_rst.no_stale", seen, 0);
        run_op("after_rst", 6'd33, 6'h0F, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFFE, 66, 32'd3, 0, 6'h00, 0, 4'b0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/div_sequencer.md
# div_sequencer

Shared iterative integer divide unit for the multithreaded SPARC V8 integer pipeline. It executes UDIV, SDIV, UDIVCC and SDIVCC for any hardware thread. Only one divide is in flight at a time. Results go back through a valid/ready response channel tagged with the thread ID. The block produces the V8 overflow-saturated quotient, the integer condition codes, and the division-by-zero and illegal-instruction traps.

## Interface
- NTHREAD, 64: number of hardware threads.
- TIDW, 6: thread ID width, equal to log2(NTHREAD).
- clk  in  1: single clock.
- rst  in  1: reset, asynchronous and active-high.
- req_valid  in  1: a divide request is presented.
- req_ready  out  1: the unit can accept a request; high only in IDLE.
- req_tid  in  TIDW: requesting thread.
- req_op  in  6: op3 field. 0x0E=UDIV, 0x0F=SDIV, 0x1E=UDIVCC, 0x1F=SDIVCC.
- req_y  in  32: Y register, the upper half of the dividend.
- req_rs1  in  32: lower half of the dividend.
- req_op2  in  32: divisor (rs2 or sign-extended simm13).
- abort  in  1: squash the in-flight operation (thread replay or flush).
- resp_valid  out  1: result is available.
- resp_ready  in  1: consumer takes the result.
- resp_tid  out  TIDW: thread of the result.
- resp_result  out  32: quotient written to rd.
- resp_icc_we  out  1: write icc. High only for CC ops without a trap.
- resp_icc  out  4: {N,Z,V,C}.
- resp_trap  out  1: the operation traps; rd and icc are not written.
- resp_tt  out  6: trap type. 0x2A (division by zero) or 0x02 (illegal instruction).

## Operation
- States: IDLE, CALC, FIX, RESP.
- Accept happens when req_valid && req_ready. On accept the unit latches tid, op, the 64-bit dividend {req_y, req_rs1} and the divisor.
- Accept with an op other than the four divide ops: go to RESP with resp_trap=1, tt=0x02.
- Accept with divisor == 0: go to RESP with resp_trap=1, tt=0x2A.
- Otherwise go to CALC.
- Signed ops: convert dividend and divisor to magnitudes on accept, and record the result sign as the XOR of the two sign bits.
  - A dividend of -2^63 has magnitude 2^63, which must be represented as an unsigned 64-bit value.
- CALC: restoring division on the 64-bit magnitude with a 33-bit partial remainder. One quotient bit per cycle, MSB first. A 7-bit counter counts 64 iterations, then the unit moves to FIX.
- FIX, unsigned ops: if q > 0xFFFFFFFF, result=0xFFFFFFFF and V=1. Otherwise result=q[31:0] and V=0.
- FIX, signed ops: truncate toward zero and apply the recorded sign.
  - Positive q > 0x7FFFFFFF: result=0x7FFFFFFF, V=1.
  - Negative with magnitude > 0x80000000: result=0x80000000, V=1.
  - Otherwise result is the two's-complement 32-bit value and V=0.
- icc: N=result[31]; Z=(result==0); V as above; C=0. resp_icc_we = CC op && !trap.
- RESP: resp_valid=1, with all resp_* outputs held stable until resp_ready. The handshake returns the unit to IDLE.
- abort in CALC, FIX or RESP: go to IDLE next cycle with no response. In RESP, abort overrides a same-cycle resp_ready, so the response is not counted as delivered.
- abort in IDLE is ignored. abort in the same cycle as an accept does not squash the request being accepted.
- The remainder is discarded; V8 does not write Y on divide.

## Timing
- Reset values: state=IDLE, req_ready=1, resp_valid=0, resp_trap=0, resp_icc_we=0, resp_tt=0, resp_tid=0, resp_result=0, resp_icc=0.
- req_ready is a registered function of state (state==IDLE). It has no combinational path from req_valid.
- Normal divide: accept in cycle T, CALC in T+1..T+64, FIX in T+65, resp_valid first high in T+66.
- Trap (zero divisor or illegal op): resp_valid first high in T+1.
- Back-to-back: response handshake in cycle R gives req_ready=1 in R+1. The earliest next accept is R+1.
- Maximum throughput is one divide per 67 cycles when resp_ready is held high.
- rst asserted mid-operation clears all state immediately. No response is produced for the interrupted operation.

## Test plan
- UDIV: Y=0, rs1=100, op2=7, tid=5 -> result=14, tid=5, no trap, icc_we=0. resp_valid at accept+66.
- UDIVCC: Y=1, rs1=0, op2=1 -> result=0xFFFFFFFF, icc={N=1,Z=0,V=1,C=0}, icc_we=1.
- SDIVCC: Y=0xFFFFFFFF, rs1=0xFFFFFF9C (-100), op2=7 -> result=0xFFFFFFF2 (-14), icc={1,0,0,0}.
- SDIVCC: Y=0, rs1=0x80000000, op2=1 -> result=0x7FFFFFFF, V=1.
- SDIV: Y=0xFFFFFFFF, rs1=0, op2=1 -> result=0x80000000, V=1.
- UDIV with op2=0 -> resp_trap=1, tt=0x2A, icc_we=0, resp_valid at accept+1.
- req_op=0x00 -> resp_trap=1, tt=0x02 at accept+1.
- abort at accept+30 -> no resp_valid, req_ready=1 at accept+31, and the next request completes correctly.
- resp_ready held low for 10 cycles in RESP -> outputs stay stable and req_ready stays 0.
- rst pulse mid-CALC -> every output returns to its reset value and no stale response ever appears.
